// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with redirect, hold and flush handling
// Single outstanding request; redirects never disturb an un-acked address.
module ifetch_unit #(
  parameter logic [31:2] RESET_PC = 30'h0C00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] npc_in,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:2] inst_pc,
  output logic [31:2] four_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:2] pc_q, pc_d;
  logic [31:2] target_q, target_d;
  logic [31:0] inst_q, inst_d;
  logic [31:2] inst_pc_q, inst_pc_d;
  logic [31:2] four_pc_q, four_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      target_q  <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      four_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      four_pc_q <= four_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    four_pc_d = four_pc_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = npc_in;
      end

      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d = npc_in;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            four_pc_d = pc_q + 30'd1;
            pc_d      = pc_q + 30'd1;
            state_d   = HOLD;
          end
        end else if (redirect) begin
          // Request stays on the bus; remember where to go once it retires.
          target_d = npc_in;
          state_d  = FLUSH;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = npc_in;
          state_d = FETCH;
        end else if (inst_ready) begin
          state_d = FETCH;
        end
      end

      FLUSH: begin
        if (redirect) target_d = npc_in;
        if (imem_ack) begin
          pc_d    = redirect ? npc_in : target_q;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = (state_q == FETCH) || (state_q == FLUSH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign four_pc    = four_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit
// Transaction-level model compared every cycle, plus literal directed checks.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] npc_in;
  logic        redirect;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:2] inst_pc;
  logic [31:2] four_pc;

  int n_pass = 0;
  int n_chk  = 0;

  ifetch_unit #(.RESET_PC(30'h0C00)) dut (
    .clk        (clk),
    .rst        (rst),
    .npc_in     (npc_in),
    .redirect   (redirect),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .four_pc    (four_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:2] a);
    return {a, 2'b01} ^ 32'h5A5A_5A5A;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: has the fetcher started, does it hold an instruction,
  // is the current request a doomed one whose data must be thrown away.
  bit          m_init = 0;
  bit          m_started, m_have, m_discard;
  logic [31:2] m_pc, m_tgt, m_ipc, m_four;
  logic [31:0] m_inst;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_started = 0; m_have = 0; m_discard = 0;
      m_pc = 30'h0C00; m_tgt = '0; m_inst = '0; m_ipc = '0; m_four = '0;
    end else if (m_init) begin
      if (!m_started) begin
        m_started = 1;
        if (redirect) m_pc = npc_in;
      end else if (m_have) begin
        if (redirect) begin m_have = 0; m_pc = npc_in; end
        else if (inst_ready) m_have = 0;
      end else if (m_discard) begin
        if (imem_ack) begin m_pc = redirect ? npc_in : m_tgt; m_discard = 0; end
        else if (redirect) m_tgt = npc_in;
      end else if (imem_ack) begin
        if (redirect) m_pc = npc_in;
        else begin
          m_inst = mem_word(m_pc); m_ipc = m_pc; m_four = m_pc + 30'd1;
          m_pc = m_pc + 30'd1; m_have = 1;
        end
      end else if (redirect) begin
        m_tgt = npc_in; m_discard = 1;
      end
    end
  end

  bit          last_pending = 0;
  logic [31:2] last_addr;

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp_req",     32'(imem_req),   32'(m_started && !m_have));
      chk("cmp_valid",   32'(inst_valid), 32'(m_have));
      chk("cmp_addr",    32'(imem_addr),  32'(m_pc));
      chk("cmp_inst",    inst,            m_inst);
      chk("cmp_inst_pc", 32'(inst_pc),    32'(m_ipc));
      chk("cmp_four_pc", 32'(four_pc),    32'(m_four));
      if (last_pending) chk("addr_stable", 32'(imem_addr), 32'(last_addr));
      last_pending = imem_req && !imem_ack && !rst;
      last_addr    = imem_addr;
    end
  end

  task automatic drive(input logic r, input logic rd, input logic [31:2] npc,
                       input logic ack, input logic rdy);
    rst = r; redirect = rd; npc_in = npc; imem_ack = ack; inst_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, '0, 0, 0);
    tick(); tick();
    chk("rst_req",     32'(imem_req),   32'd0);
    chk("rst_valid",   32'(inst_valid), 32'd0);
    chk("rst_addr",    32'(imem_addr),  32'h0C00);
    chk("rst_inst_pc", 32'(inst_pc),    32'd0);
    chk("rst_four_pc", 32'(four_pc),    32'd0);
    chk("rst_inst",    inst,            32'd0);

    drive(0, 0, '0, 1, 1);
    tick();
    chk("c1_req",  32'(imem_req),  32'd1);
    chk("c1_addr", 32'(imem_addr), 32'h0C00);
    tick();
    chk("c2_valid",   32'(inst_valid), 32'd1);
    chk("c2_inst_pc", 32'(inst_pc),    32'h0C00);
    chk("c2_four_pc", 32'(four_pc),    32'h0C01);
    chk("c2_inst",    inst,            32'h5A5A_6A5B);
    tick();
    chk("c3_addr", 32'(imem_addr), 32'h0C01);
    chk("c3_req",  32'(imem_req),  32'd1);

    drive(0, 0, '0, 1, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid",   32'(inst_valid), 32'd1);
      chk("hold_noreq",   32'(imem_req),   32'd0);
      chk("hold_inst_pc", 32'(inst_pc),    32'h0C01);
    end
    drive(0, 0, '0, 1, 1);
    tick();
    chk("rel_addr", 32'(imem_addr), 32'h0C02);

    drive(0, 1, 30'h0D00, 0, 1);
    tick();
    drive(0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_addr", 32'(imem_addr), 32'h0C02);
      chk("flush_nov",  32'(inst_valid), 32'd0);
    end
    drive(0, 0, '0, 1, 1);
    tick();
    chk("flush_next", 32'(imem_addr), 32'h0D00);
    chk("flush_nov2", 32'(inst_valid), 32'd0);
    tick();
    chk("post_flush_pc", 32'(inst_pc), 32'h0D00);

    drive(0, 1, 30'h0E10, 1, 1);
    tick();
    chk("hredir_valid", 32'(inst_valid), 32'd0);
    chk("hredir_addr",  32'(imem_addr),  32'h0E10);

    drive(0, 1, 30'h0111, 0, 1); tick();
    drive(0, 1, 30'h0222, 0, 1); tick();
    drive(0, 1, 30'h0333, 1, 1); tick();
    chk("flush_same_cyc", 32'(imem_addr), 32'h0333);
    drive(0, 1, 30'h0444, 0, 1); tick();
    drive(0, 1, 30'h0555, 0, 1); tick();
    drive(0, 0, '0, 1, 1); tick();
    chk("flush_latest", 32'(imem_addr), 32'h0555);

    drive(0, 1, 30'h3FFF_FFFF, 1, 1); tick();
    chk("fredir_addr",  32'(imem_addr),  32'h3FFF_FFFF);
    chk("fredir_valid", 32'(inst_valid), 32'd0);
    drive(0, 0, '0, 1, 0); tick();
    chk("wrap_inst_pc", 32'(inst_pc), 32'h3FFF_FFFF);
    chk("wrap_four_pc", 32'(four_pc), 32'd0);
    drive(0, 0, '0, 1, 1); tick();
    chk("wrap_addr", 32'(imem_addr), 32'd0);

    drive(0, 1, 30'h0777, 0, 1); tick();
    drive(1, 0, '0, 1, 1); tick();
    chk("rstf_req",   32'(imem_req),   32'd0);
    chk("rstf_valid", 32'(inst_valid), 32'd0);
    chk("rstf_addr",  32'(imem_addr),  32'h0C00);
    drive(0, 1, 30'h0123, 0, 1); tick();
    chk("idle_redir", 32'(imem_addr), 32'h0123);

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0),
            30'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1));
      tick();
    end
    drive(0, 0, '0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
